// File: rtl/axil_reg_arbiter_pkg.sv
// Shared types and constants for the two-requester AXI4-Lite register arbiter.
package axil_reg_arbiter_pkg;

    typedef enum logic [2:0] {IDLE, WR, WB, RA, RD, DONE} state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int DEFAULT_TIMEOUT = 256;

endpackage

// File: rtl/axil_reg_arbiter_rr_arb2.sv
// Two-way round-robin grant: ptr names the requester favoured when both ask.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant
);

    assign grant[0] = req[0] & (~req[1] | ~ptr);
    assign grant[1] = req[1] & (~req[0] |  ptr);

endmodule

// File: rtl/axil_reg_arbiter.sv
// Arbitrates two register requesters onto one AXI4-Lite master port,
// one transaction at a time, with a per-transaction timeout.
module axil_reg_arbiter
    import axil_reg_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic [1:0]          req_valid,
    input  logic [1:0]          req_write,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          req_ready,
    output logic [1:0]          req_done,
    output logic [DATA_W-1:0]   req_rdata,
    output logic [1:0]          req_resp,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [2:0]          m_awprot,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [2:0]          m_arprot,
    output logic                m_arvalid,
    input  logic                m_arready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rvalid,
    output logic                m_rready
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t              state;
    logic                ptr;
    logic                owner;
    logic                aw_done;
    logic                w_done;
    logic [CNT_W-1:0]    cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [1:0]          grant;
    logic                sel_write;
    logic                active;
    logic                expired;
    logic                aw_fire;
    logic                w_fire;
    logic [1:0]          owner_mask;

    rr_arb2 u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    assign sel_write  = grant[1] ? req_write[1] : req_write[0];
    assign active     = (state == WR) || (state == WB) || (state == RA) || (state == RD);
    assign expired    = active && (cnt == CNT_W'(TIMEOUT));
    assign aw_fire    = m_awvalid & m_awready;
    assign w_fire     = m_wvalid & m_wready;
    assign owner_mask = owner ? 2'b10 : 2'b01;

    // Strobes only mean anything alongside wvalid, so they idle low with it.
    assign m_awprot = 3'b000;
    assign m_arprot = 3'b000;
    assign m_wstrb  = {(DATA_W/8){m_wvalid}};
    assign m_awaddr = addr_q;
    assign m_araddr = addr_q;
    assign m_wdata  = wdata_q;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            owner     <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            cnt       <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            req_ready <= '0;
            req_done  <= '0;
            req_rdata <= '0;
            req_resp  <= '0;
            m_awvalid <= 1'b0;
            m_wvalid  <= 1'b0;
            m_bready  <= 1'b0;
            m_arvalid <= 1'b0;
            m_rready  <= 1'b0;
        end else begin
            req_ready <= '0;
            req_done  <= '0;
            if (active) cnt <= cnt + 1'b1;

            if (expired) begin
                m_awvalid <= 1'b0;
                m_wvalid  <= 1'b0;
                m_bready  <= 1'b0;
                m_arvalid <= 1'b0;
                m_rready  <= 1'b0;
                req_resp  <= RESP_SLVERR;
                req_rdata <= '0;
                req_done  <= owner_mask;
                state     <= DONE;
            end else begin
                case (state)
                    IDLE: if (|grant) begin
                        req_ready <= grant;
                        owner     <= grant[1];
                        ptr       <= ~grant[1];
                        addr_q    <= grant[1] ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
                        wdata_q   <= grant[1] ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
                        cnt       <= '0;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        state     <= sel_write ? WR : RA;
                    end
                    // AW and W are raised on the first WR cycle and retire independently.
                    WR: begin
                        if (!aw_done) begin
                            if (aw_fire) begin
                                m_awvalid <= 1'b0;
                                aw_done   <= 1'b1;
                            end else m_awvalid <= 1'b1;
                        end
                        if (!w_done) begin
                            if (w_fire) begin
                                m_wvalid <= 1'b0;
                                w_done   <= 1'b1;
                            end else m_wvalid <= 1'b1;
                        end
                        if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                            m_bready <= 1'b1;
                            state    <= WB;
                        end
                    end
                    WB: if (m_bvalid) begin
                        m_bready  <= 1'b0;
                        req_resp  <= m_bresp;
                        req_rdata <= '0;
                        req_done  <= owner_mask;
                        state     <= DONE;
                    end
                    RA: begin
                        if (m_arvalid && m_arready) begin
                            m_arvalid <= 1'b0;
                            m_rready  <= 1'b1;
                            state     <= RD;
                        end else m_arvalid <= 1'b1;
                    end
                    RD: if (m_rvalid) begin
                        m_rready  <= 1'b0;
                        req_rdata <= m_rdata;
                        req_resp  <= m_rresp;
                        req_done  <= owner_mask;
                        state     <= DONE;
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axil_reg_arbiter.sv
// Directed bench: simple AXI4-Lite slave model with bench-driven readies.
module tb_axil_reg_arbiter;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [1:0]  req_valid, req_write;
    logic [63:0] req_addr, req_wdata;
    logic [1:0]  req_ready, req_done, req_resp;
    logic [31:0] req_rdata;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [2:0]  m_awprot, m_arprot;
    logic [3:0]  m_wstrb;
    logic        m_awvalid, m_awready, m_wvalid, m_wready;
    logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;
    logic [1:0]  m_bresp, m_rresp;

    int checks = 0;
    int errors = 0;

    always #5 ACLK = ~ACLK;

    axil_reg_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .req_done(req_done), .req_rdata(req_rdata), .req_resp(req_resp),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    // Slave model: four words addressed by addr[3:2], B/R one cycle after handshake.
    logic [31:0] mem [4];
    logic        aw_seen, w_seen;
    logic [31:0] aw_addr_s, w_data_s;
    logic        aw_fire, w_fire;
    logic [31:0] wr_addr, wr_data;

    assign aw_fire = m_awvalid & m_awready;
    assign w_fire  = m_wvalid & m_wready;
    assign wr_addr = aw_fire ? m_awaddr : aw_addr_s;
    assign wr_data = w_fire ? m_wdata : w_data_s;

    always @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_seen <= 1'b0; w_seen <= 1'b0; aw_addr_s <= '0; w_data_s <= '0;
            m_bvalid <= 1'b0; m_bresp <= 2'b00; m_rvalid <= 1'b0; m_rdata <= '0; m_rresp <= 2'b00;
            mem[0] <= '0; mem[1] <= 32'habcd0001; mem[2] <= '0; mem[3] <= '0;
        end else begin
            if (aw_fire) begin aw_seen <= 1'b1; aw_addr_s <= m_awaddr; end
            if (w_fire)  begin w_seen  <= 1'b1; w_data_s  <= m_wdata;  end
            if (m_bvalid && m_bready) m_bvalid <= 1'b0;
            else if (!m_bvalid && (aw_seen || aw_fire) && (w_seen || w_fire)) begin
                m_bvalid <= 1'b1;
                aw_seen  <= 1'b0;
                w_seen   <= 1'b0;
                mem[wr_addr[3:2]] <= wr_data;
            end
            if (m_rvalid && m_rready) m_rvalid <= 1'b0;
            else if (m_arvalid && m_arready) begin
                m_rvalid <= 1'b1;
                m_rdata  <= mem[m_araddr[3:2]];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge ACLK);
    endtask

    task automatic set_req(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d);
        req_valid[i] = 1'b1;
        req_write[i] = wr;
        req_addr[i*32 +: 32]  = a;
        req_wdata[i*32 +: 32] = d;
    endtask

    initial begin
        ARESET = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
        step(); step();
        chk("reset_outputs", 64'(|{req_ready, req_done, req_rdata, req_resp, m_awvalid, m_wvalid,
                                   m_bready, m_arvalid, m_rready, m_awaddr, m_wdata, m_wstrb}), 64'd0);
        ARESET = 1'b0;
        step();

        // Both requesters: req0 read 0x4, req1 write 0xdead0011 -> 0x8
        set_req(0, 1'b0, 32'h4, 32'h0);
        set_req(1, 1'b1, 32'h8, 32'hdead0011);
        step(); chk("rr_first_grant", req_ready, 2'b01);
        req_valid[0] = 1'b0;
        step(); chk("rd_arvalid", m_arvalid, 1'b1); chk("rd_araddr", m_araddr, 32'h4);
        step(); chk("rd_rready", m_rready, 1'b1);
        step(); chk("rd_done", req_done, 2'b01); chk("rd_rdata", req_rdata, 32'habcd0001);
                chk("rd_resp", req_resp, 2'b00);
        step(); chk("rr_gap", req_ready, 2'b00);
        step(); chk("rr_second_grant", req_ready, 2'b10);
        req_valid = '0;
        step(); chk("wr1_aw", {m_awvalid, m_wvalid}, 2'b11); chk("wr1_awaddr", m_awaddr, 32'h8);
                chk("wr1_wdata", m_wdata, 32'hdead0011);
        step();
        step(); chk("wr1_done", req_done, 2'b10); chk("wr1_rdata", req_rdata, 32'h0);
                chk("wr1_mem", mem[2], 32'hdead0011);
        step();

        // Single writer, slave always ready
        set_req(0, 1'b1, 32'h0, 32'h0101ffff);
        step(); chk("wr0_ready", req_ready, 2'b01);
        req_valid = '0;
        step(); chk("wr0_valids", {m_awvalid, m_wvalid}, 2'b11); chk("wr0_awaddr", m_awaddr, 32'h0);
                chk("wr0_wdata", m_wdata, 32'h0101ffff); chk("wr0_wstrb", m_wstrb, 4'hf);
                chk("wr0_prot", {m_awprot, m_arprot}, 6'd0);
        step(); chk("wr0_bready", m_bready, 1'b1); chk("wr0_no_early_done", req_done, 2'b00);
        step(); chk("wr0_done", req_done, 2'b01); chk("wr0_resp", req_resp, 2'b00);
        step(); chk("wr0_done_pulse", req_done, 2'b00);
        step();

        // W channel held off after AW handshake
        m_wready = 1'b0;
        set_req(0, 1'b1, 32'hc, 32'h5555aaaa);
        step(); chk("wst_ready", req_ready, 2'b01);
        req_valid = '0;
        step(); chk("wst_valids", {m_awvalid, m_wvalid}, 2'b11);
        for (int i = 2; i <= 7; i++) begin
            step(); chk($sformatf("wst_hold_c%0d", i), {m_awvalid, m_wvalid, m_bready}, 3'b010);
        end
        m_wready = 1'b1;
        step(); chk("wst_bphase", {m_awvalid, m_wvalid, m_bready}, 3'b001);
        step(); chk("wst_done", req_done, 2'b01);
        step(); chk("wst_single_done", req_done, 2'b00);
        step();

        // Reset during WB, then normal write + readback
        set_req(0, 1'b1, 32'hc, 32'h12345678);
        step(); req_valid = '0;
        step();
        step(); chk("rst_in_wb", m_bready, 1'b1);
        ARESET = 1'b1;
        #1 chk("rst_async_outputs", 64'(|{req_ready, req_done, req_rdata, req_resp, m_awvalid, m_wvalid,
                                          m_bready, m_arvalid, m_rready, m_awaddr, m_wdata, m_wstrb}), 64'd0);
        step(); step();
        set_req(0, 1'b1, 32'hc, 32'hbeef0011);
        ARESET = 1'b0;
        #1 chk("no_grant_before_edge", req_ready, 2'b00);
        step(); chk("post_rst_grant", req_ready, 2'b01);
        req_valid = '0;
        step(); step();
        step(); chk("post_rst_wr_done", req_done, 2'b01);
        step();
        set_req(0, 1'b0, 32'hc, 32'h0);
        step(); req_valid = '0;
        step(); step();
        step(); chk("readback_done", req_done, 2'b01); chk("readback_data", req_rdata, 32'hbeef0011);
        step();

        // AR never accepted -> timeout abort
        m_arready = 1'b0;
        set_req(0, 1'b0, 32'h4, 32'h0);
        step(); chk("to_grant", req_ready, 2'b01);
        req_valid = '0;
        step(); chk("to_arvalid_c1", m_arvalid, 1'b1);
        for (int i = 2; i <= 16; i++) step();
        chk("to_arvalid_c16", {m_arvalid, req_done}, 3'b100);
        step(); chk("to_done", req_done, 2'b01); chk("to_resp", req_resp, 2'b10);
                chk("to_rdata", req_rdata, 32'h0); chk("to_arvalid_drop", m_arvalid, 1'b0);
        step(); chk("to_done_pulse", req_done, 2'b00);
        m_arready = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axil_reg_arbiter.md
AXIL_REG_ARBITER -- requirements
Module: axil_reg_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI4-Lite address width.
REQ-002 SHALL have parameter DATA_W, default 32, AXI4-Lite data width.
REQ-003 SHALL have parameter TIMEOUT, default 256, cycles allowed per transaction before forced abort.
REQ-004 SHALL have port ACLK, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port ARESET, input, 1, reset, asynchronous and active-high.
REQ-006 SHALL have port req_valid, input, 2, per-requester transaction request.
REQ-007 SHALL have port req_write, input, 2, per-requester 1=write, 0=read.
REQ-008 SHALL have port req_addr, input, 2*ADDR_W, packed per-requester address; requester i uses slice i.
REQ-009 SHALL have port req_wdata, input, 2*DATA_W, packed per-requester write data.
REQ-010 SHALL have port req_ready, output, 2, one-cycle grant/accept pulse per requester.
REQ-011 SHALL have port req_done, output, 2, one-cycle completion pulse per requester.
REQ-012 SHALL have port req_rdata, output, DATA_W, read data; valid with any req_done bit.
REQ-013 SHALL have port req_resp, output, 2, AXI response; valid with any req_done bit.
REQ-014 SHALL have ports m_awaddr/m_awprot/m_awvalid (out), m_awready (in): AW channel, widths ADDR_W/3/1/1.
REQ-015 SHALL have ports m_wdata/m_wstrb/m_wvalid (out), m_wready (in): W channel, widths DATA_W/DATA_W/8/1.
REQ-016 SHALL have ports m_bresp/m_bvalid (in), m_bready (out): B channel, widths 2/1/1.
REQ-017 SHALL have ports m_araddr/m_arprot/m_arvalid (out), m_arready (in): AR channel, widths ADDR_W/3/1/1.
REQ-018 SHALL have ports m_rdata/m_rresp/m_rvalid (in), m_rready (out): R channel, widths DATA_W/2/1/1.

Function
REQ-019 SHALL implement FSM states IDLE, WR (AW+W), WB, RA, RD, DONE.
REQ-020 In IDLE with any req_valid set, SHALL grant by round-robin: if both set, grant the requester not granted last; pulse req_ready for the grantee; latch write, addr, wdata; go to WR (write) or RA (read) next cycle.
REQ-021 Single requester valid SHALL be granted regardless of the round-robin pointer; pointer updates on every grant.
REQ-022 In WR, m_awvalid and m_wvalid SHALL assert together; each drops independently after its own handshake; advance to WB once both handshakes have completed (same cycle or different cycles).
REQ-023 In WB, m_bready=1; on m_bvalid capture m_bresp, go to DONE.
REQ-024 In RA, m_arvalid=1 until m_arready; then RD with m_rready=1; on m_rvalid capture m_rdata/m_rresp, go to DONE.
REQ-025 m_awprot and m_arprot SHALL be 3'b000; m_wstrb all ones.
REQ-026 VALID signals SHALL NOT deassert before their handshake except on timeout or reset.
REQ-027 In DONE, SHALL pulse req_done for the grantee for one cycle with req_rdata/req_resp held stable; return to IDLE; earliest next grant is the following cycle.
REQ-028 req_rdata SHALL be 0 on write completion.
REQ-029 Latency, no backpressure: grant at cycle 0, AW/W or AR valid at 1, done pulse at 3 (read: AR at 1, R at 2, done at 3).
REQ-030 A cycle counter SHALL run from grant; reaching TIMEOUT in WR/WB/RA/RD SHALL drop all master VALID/READY, go to DONE with req_resp=2'b10 and req_rdata=0.
REQ-031 req_valid deassertion after grant SHALL NOT abort the transaction.

Reset
REQ-032 ARESET SHALL force state IDLE, round-robin pointer to favour requester 0, timeout counter 0, and all outputs to 0, asynchronously, including mid-transaction.
REQ-033 After ARESET release, the first grant SHALL occur no earlier than the first rising ACLK edge.

Structure
REQ-034 A shared package SHALL hold the FSM state enum, AXI response constants (OKAY=00, EXOKAY=01, SLVERR=10), and the default TIMEOUT.
REQ-035 The round-robin grant logic SHALL be a sub-module rr_arb2 (inputs req[1:0], pointer; output one-hot grant).

Verification
REQ-036 Only req 0 writes 0x0101FFFF to 0x0 (slave ready immediately) -> req_ready[0] at cycle 0, AW/W at 1, req_done[0] at 3, resp 00.
REQ-037 Both requesters valid: req 0 reads 0x4 returning 0xabcd0001, req 1 writes 0xdead0011 to 0x8 -> req 0 served first, then req 1; req_rdata=0xabcd0001 on req 0 done.
REQ-038 Slave holds m_wready low 5 cycles after m_awready -> m_awvalid drops after AW handshake; B phase only after W handshake; single done.
REQ-039 Slave never asserts m_arready, TIMEOUT=16 -> req_done at cycle 17 with resp 10, rdata 0.
REQ-040 ARESET asserted while in WB -> all outputs 0 immediately; next request after release completes normally with 0xbeef0011 readback.
